fp_to_fixed_pipe: RTL

//  Streaming IEEE-754 single -> signed fixed-point converter. 3-stage valid/ready pipeline.

---
 rtl/fp_to_fixed_pipe.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fp_to_fixed_pipe.sv
// Streaming IEEE-754 single to signed fixed-point converter. The pipeline has three stages:
// unpack/classify, align, and round/saturate. All stages advance together under one valid/ready handshake.
module fp_to_fixed_pipe #(
    parameter int WORD_LENGTH = 21,
    parameter int FRAC_BITS   = 19,
    parameter int ROUND_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_data,
    output logic                   out_ovf,
    output logic                   out_nan,
    output logic                   out_unf
);
    localparam int WL = WORD_LENGTH;
    localparam int XW = WL + 25;
    localparam logic signed [9:0] SH_OFS = 10'(FRAC_BITS - 150);
    // A left shift of sh puts the hidden bit at 23+sh; from bit WL+1 upward it leaves the working width.
    localparam logic signed [9:0] SH_OVF = 10'(WL - 22);
    localparam logic [WL+1:0] POS_LIM = (WL+2)'((64'd1 << (WL-1)) - 64'd1);
    localparam logic [WL+1:0] NEG_LIM = (WL+2)'(64'd1 << (WL-1));
    localparam logic [WL-1:0] SAT_POS = POS_LIM[WL-1:0];
    localparam logic [WL-1:0] SAT_NEG = NEG_LIM[WL-1:0];

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORM   = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } fp_class_e;

    logic            adv_s;
    fp_class_e       cls_s;

    logic            s1_valid_r;
    logic            s1_sign_r;
    logic [7:0]      s1_exp_r;
    logic [23:0]     s1_mant_r;
    fp_class_e       s1_cls_r;

    logic signed [9:0] sh_s;
    logic [9:0]      nsh_s;
    logic [XW-1:0]   ext_s;
    logic [XW-1:0]   lsh_s;
    logic [48:0]     rs_s;
    logic [XW-1:0]   rw_s;
    logic [WL:0]     al_mag_s;
    logic            al_guard_s;
    logic            al_sticky_s;
    logic            al_ovf_s;

    logic            s2_valid_r;
    logic            s2_sign_r;
    fp_class_e       s2_cls_r;
    logic [WL:0]     s2_mag_r;
    logic            s2_guard_r;
    logic            s2_sticky_r;
    logic            s2_ovf_r;

    logic            inc_s;
    logic [WL+1:0]   rnd_s;
    logic [WL-1:0]   res_data_s;
    logic            res_ovf_s;
    logic            res_nan_s;
    logic            res_unf_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // Classify the incoming word from its exponent and fraction fields.
    always_comb begin
        if (in_data[30:23] == 8'd0) begin
            cls_s = (in_data[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
        end else if (in_data[30:23] == 8'hFF) begin
            cls_s = (in_data[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            cls_s = CLS_NORM;
        end
    end

    // Align the mantissa to the fixed-point grid, keeping guard/sticky on right shifts.
    always_comb begin
        sh_s  = $signed({2'b00, s1_exp_r}) + SH_OFS;
        nsh_s = 10'(-sh_s);
        ext_s = {{(XW-24){1'b0}}, s1_mant_r};
        lsh_s = ext_s << $unsigned(sh_s);
        rs_s  = {s1_mant_r, 25'd0} >> nsh_s;
        rw_s  = {{(XW-24){1'b0}}, rs_s[48:25]};
        if (sh_s >= 10'sd0) begin
            al_mag_s    = lsh_s[WL:0];
            al_guard_s  = 1'b0;
            al_sticky_s = 1'b0;
            al_ovf_s    = (sh_s >= SH_OVF) | (|lsh_s[XW-1:WL+1]);
        end else begin
            al_mag_s    = rw_s[WL:0];
            al_guard_s  = rs_s[24];
            al_sticky_s = |rs_s[23:0];
            al_ovf_s    = |rw_s[XW-1:WL+1];
        end
    end

    // Round, apply sign, saturate and resolve the special classes into data and flags.
    always_comb begin
        res_data_s = {WL{1'b0}};
        res_ovf_s  = 1'b0;
        res_nan_s  = 1'b0;
        res_unf_s  = 1'b0;
        case (ROUND_MODE)
            1:       inc_s = s2_guard_r;
            // Mode 2 is round-to-nearest-even, the reason the sticky bit is carried.
            2:       inc_s = s2_guard_r & (s2_sticky_r | s2_mag_r[0]);
            default: inc_s = 1'b0;
        endcase
        rnd_s = {1'b0, s2_mag_r} + {{(WL+1){1'b0}}, inc_s};
        case (s2_cls_r)
            CLS_ZERO:   res_unf_s = 1'b0;
            CLS_DENORM: res_unf_s = 1'b1;
            CLS_NAN:    res_nan_s = 1'b1;
            CLS_INF: begin
                res_ovf_s  = 1'b1;
                res_data_s = s2_sign_r ? SAT_NEG : SAT_POS;
            end
            CLS_NORM: begin
                if (!s2_sign_r) begin
                    if (s2_ovf_r || (rnd_s > POS_LIM)) begin
                        res_ovf_s  = 1'b1;
                        res_data_s = SAT_POS;
                    end else begin
                        res_data_s = rnd_s[WL-1:0];
                    end
                end else begin
                    if (s2_ovf_r || (rnd_s > NEG_LIM)) begin
                        res_ovf_s  = 1'b1;
                        res_data_s = SAT_NEG;
                    end else begin
                        res_data_s = {WL{1'b0}} - rnd_s[WL-1:0];
                    end
                end
                res_unf_s = ~res_ovf_s & (res_data_s == {WL{1'b0}});
            end
            default: res_data_s = {WL{1'b0}};
        endcase
    end

    // Pipeline registers: every stage shifts on adv, everything clears on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_exp_r    <= 8'd0;
            s1_mant_r   <= 24'd0;
            s1_cls_r    <= CLS_ZERO;
            s2_valid_r  <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_cls_r    <= CLS_ZERO;
            s2_mag_r    <= {(WL+1){1'b0}};
            s2_guard_r  <= 1'b0;
            s2_sticky_r <= 1'b0;
            s2_ovf_r    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= {WL{1'b0}};
            out_ovf     <= 1'b0;
            out_nan     <= 1'b0;
            out_unf     <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r  <= in_valid;
            s1_sign_r   <= in_data[31];
            s1_exp_r    <= in_data[30:23];
            s1_mant_r   <= {1'b1, in_data[22:0]};
            s1_cls_r    <= cls_s;
            s2_valid_r  <= s1_valid_r;
            s2_sign_r   <= s1_sign_r;
            s2_cls_r    <= s1_cls_r;
            s2_mag_r    <= al_mag_s;
            s2_guard_r  <= al_guard_s;
            s2_sticky_r <= al_sticky_s;
            s2_ovf_r    <= al_ovf_s;
            out_valid   <= s2_valid_r;
            out_data    <= res_data_s;
            out_ovf     <= res_ovf_s;
            out_nan     <= res_nan_s;
            out_unf     <= res_unf_s;
        end
    end
endmodule
